// File: rtl/mips_cpu_regfile_pkg.sv
// Shared types and default widths for the MIPS register file.
package mips_cpu_regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NREAD      = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/mips_cpu_regfile_scoreboard.sv
// Pending-write (busy) bit per register; set and clear requests, set wins on collision.
module mips_cpu_regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_enable,
  input  logic [ADDR_WIDTH-1:0] set_index,
  input  logic                  clear_enable,
  input  logic [ADDR_WIDTH-1:0] clear_index,
  output logic [DEPTH-1:0]      busy
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  // Register 0 is hardwired zero, so it can never carry a pending write.
  assign busy_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clear_hit;
      assign set_hit   = set_enable   && (set_index   == ADDR_WIDTH'(gi));
      assign clear_hit = clear_enable && (clear_index == ADDR_WIDTH'(gi));
      assign busy_next[gi] = set_hit ? 1'b1 : (clear_hit ? 1'b0 : busy_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/mips_cpu_regfile_sb.sv
// MIPS register file with load scoreboard and power-up clear sequence.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_cpu_regfile_sb
  import mips_cpu_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NREAD      = DEFAULT_NREAD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREAD*ADDR_WIDTH-1:0] read_index,
  output logic [NREAD*DATA_WIDTH-1:0] read_data,
  output logic [NREAD-1:0]            read_busy,
  input  logic                        write_enable,
  input  logic [ADDR_WIDTH-1:0]       write_reg,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        reserve_enable,
  input  logic [ADDR_WIDTH-1:0]       reserve_reg,
  input  logic [ADDR_WIDTH-1:0]       debug_index,
  output logic [DATA_WIDTH-1:0]       debug_data,
  output logic                        ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  regfile_state_e          state_reg;
  logic [ADDR_WIDTH-1:0]   counter_reg;
  logic                    ready_reg;
  logic [DATA_WIDTH-1:0]   regfile_mem [DEPTH];
  logic [DEPTH-1:0]        sb_busy;

  logic run;
  logic init_wr;
  logic commit_wr;
  logic reserve_ok;

  assign run        = (state_reg == ST_RUN);
  assign init_wr    = reset && (state_reg == ST_INIT);
  assign commit_wr  = reset && run && write_enable && (write_reg != '0);
  assign reserve_ok = reset && run && reserve_enable && (reserve_reg != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_INIT;
      counter_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          counter_reg <= counter_reg + 1'b1;
          if (counter_reg == ADDR_WIDTH'(DEPTH - 1)) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          state_reg <= ST_RUN;
        end
        default: begin
          state_reg   <= ST_INIT;
          counter_reg <= '0;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      regfile_mem[counter_reg] <= '0;
    end else if (commit_wr) begin
      regfile_mem[write_reg] <= write_data;
    end
  end

  mips_cpu_regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_enable   (reserve_ok),
    .set_index    (reserve_reg),
    .clear_enable (commit_wr),
    .clear_index  (write_reg),
    .busy         (sb_busy)
  );

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] idx;
      logic                  idx_zero;
      logic                  fwd;

      assign idx      = read_index[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign idx_zero = (idx == '0);

`ifdef REGFILE_BYPASS_EN
      assign fwd = commit_wr && (write_reg == idx);
`else
      assign fwd = 1'b0;
`endif

      assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (!run || idx_zero) ? '0 : (fwd ? write_data : regfile_mem[idx]);
      assign read_busy[gi] = run && !idx_zero && sb_busy[idx] && !fwd;
    end
  endgenerate

  assign debug_data = run ? regfile_mem[debug_index] : '0;
  assign ready      = ready_reg;

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Scoreboard-style bench for mips_cpu_regfile_sb: stimulus queues expectations, a monitor checks them.
module tb_mips_cpu_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_READY = 0;
  localparam int K_RDATA = 1;
  localparam int K_RBUSY = 2;
  localparam int K_DEBUG = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  read_index;
  logic [NR*DW-1:0]  read_data;
  logic [NR-1:0]     read_busy;
  logic              write_enable;
  logic [AW-1:0]     write_reg;
  logic [DW-1:0]     write_data;
  logic              reserve_enable;
  logic [AW-1:0]     reserve_reg;
  logic [AW-1:0]     debug_index;
  logic [DW-1:0]     debug_data;
  logic              ready;

  mips_cpu_regfile_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NREAD      (NR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .read_index     (read_index),
    .read_data      (read_data),
    .read_busy      (read_busy),
    .write_enable   (write_enable),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reserve_enable (reserve_enable),
    .reserve_reg    (reserve_reg),
    .debug_index    (debug_index),
    .debug_data     (debug_data),
    .ready          (ready)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input int kind, input int port, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = edge_cnt;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    e.name = name;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input int p, input int idx, input logic [31:0] d, input logic b, input string name);
    read_index[p*AW +: AW] = AW'(idx);
    push(K_RDATA, p, d, name);
    push(K_RBUSY, p, {31'b0, b}, {name, "_busy"});
  endtask

  task automatic chk_dbg(input int idx, input logic [31:0] d, input string name);
    debug_index = AW'(idx);
    push(K_DEBUG, 0, d, name);
  endtask

  // Monitor: checks every queued expectation against the DUT in the cycle it was issued.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].cyc <= edge_cnt) begin
        e = expq.pop_front();
        case (e.kind)
          K_READY: act = {31'b0, ready};
          K_RDATA: act = read_data[e.port*DW +: DW];
          K_RBUSY: act = {31'b0, read_busy[e.port]};
          default: act = debug_data;
        endcase
        total++;
        if (e.cyc != edge_cnt || act !== e.exp) begin
          bad++;
          $display("FAIL %s: cycle %0d got %h want %h", e.name, edge_cnt, act, e.exp);
        end
        else begin
          $display("ok %s: cycle %0d value %h", e.name, edge_cnt, act);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    read_index = '0;
    write_enable = 1'b0;
    write_reg = '0;
    write_data = '0;
    reserve_enable = 1'b0;
    reserve_reg = '0;
    debug_index = '0;

    step(); step();
    push(K_READY, 0, 32'd0, "rst_ready");
    chk_rd(0, 7, 32'd0, 1'b0, "rst_rd");

    // Clear sequence; writes and reserves issued during it must be ignored.
    step();
    reset = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      if (n > 0) step();
      if (n < 32) begin
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hFFFF;
        reserve_enable = 1'b1; reserve_reg = 5'd6;
      end else begin
        write_enable = 1'b0; reserve_enable = 1'b0;
      end
      push(K_READY, 0, {31'b0, (n == 32)}, "init_ready");
      chk_dbg(n % 32, 32'd0, "init_dbg");
      chk_rd(0, n % 32, 32'd0, 1'b0, "init_rd");
    end

    for (int i = 0; i < 32; i++) begin
      step();
      chk_dbg(i, 32'd0, "clr_dbg");
      chk_rd(1, i, 32'd0, 1'b0, "clr_rd");
    end

    // Basic write / read, write to r0 discarded.
    step();
    write_enable = 1'b1; write_reg = 5'd2; write_data = 32'hDEADBEEF;
    chk_rd(0, 2, BYP ? 32'hDEADBEEF : 32'd0, 1'b0, "wr2_same");
    step();
    write_reg = 5'd0; write_data = 32'h1234;
    chk_rd(0, 2, 32'hDEADBEEF, 1'b0, "rd2_p0");
    chk_rd(1, 0, 32'd0, 1'b0, "wr0_same");
    chk_dbg(2, 32'hDEADBEEF, "dbg_v0");
    step();
    write_enable = 1'b0;
    chk_rd(0, 0, 32'd0, 1'b0, "rd0");
    chk_rd(1, 2, 32'hDEADBEEF, 1'b0, "rd2_p1");
    chk_dbg(0, 32'd0, "dbg_r0");

    // Reserve then write clears busy.
    step();
    reserve_enable = 1'b1; reserve_reg = 5'd8;
    chk_rd(0, 8, 32'd0, 1'b0, "rsv8_pre");
    step();
    reserve_enable = 1'b0;
    write_enable = 1'b1; write_reg = 5'd8; write_data = 32'h55;
    chk_rd(0, 8, BYP ? 32'h55 : 32'd0, BYP ? 1'b0 : 1'b1, "wr8_same");
    step();
    write_enable = 1'b0;
    chk_rd(0, 8, 32'h55, 1'b0, "rd8_p0");
    chk_rd(1, 8, 32'h55, 1'b0, "rd8_p1");

    // Reserve and write same register in one cycle: reservation wins.
    step();
    reserve_enable = 1'b1; reserve_reg = 5'd9;
    write_enable = 1'b1; write_reg = 5'd9; write_data = 32'h77;
    chk_rd(1, 9, BYP ? 32'h77 : 32'd0, 1'b0, "rsvwr9_same");
    step();
    write_enable = 1'b0;
    chk_rd(0, 9, 32'h77, 1'b1, "rsvwr9");
    step();
    reserve_reg = 5'd0;
    write_enable = 1'b1; write_reg = 5'd10; write_data = 32'hAB;
    chk_rd(0, 9, 32'h77, 1'b1, "rsv9_again");
    chk_rd(1, 10, BYP ? 32'hAB : 32'd0, 1'b0, "wr10_same");
    step();
    reserve_enable = 1'b0; write_enable = 1'b0;
    chk_rd(0, 0, 32'd0, 1'b0, "rsv0");
    chk_rd(1, 10, 32'hAB, 1'b0, "wr10_nb");

    // Same-cycle forwarding behaviour.
    step();
    write_enable = 1'b1; write_reg = 5'd4; write_data = 32'hA5A5A5A5;
    chk_rd(1, 4, BYP ? 32'hA5A5A5A5 : 32'd0, 1'b0, "byp4");
    chk_rd(0, 9, 32'h77, 1'b1, "busy9_hold");
    step();
    write_reg = 5'd9; write_data = 32'h99;
    chk_rd(0, 9, BYP ? 32'h99 : 32'h77, BYP ? 1'b0 : 1'b1, "byp9");
    chk_rd(1, 4, 32'hA5A5A5A5, 1'b0, "rd4");
    step();
    write_enable = 1'b0;
    chk_rd(0, 9, 32'h99, 1'b0, "wr9_clr");

    // Reset mid-operation with r3 busy.
    step();
    reserve_enable = 1'b1; reserve_reg = 5'd3;
    step();
    reserve_enable = 1'b0;
    reset = 1'b0;
    push(K_READY, 0, 32'd1, "rst_pre_ready");
    chk_rd(0, 3, 32'd0, 1'b1, "busy3_pre");
    step();
    push(K_READY, 0, 32'd0, "rst_mid_ready");
    chk_rd(0, 3, 32'd0, 1'b0, "rst_busy3");
    chk_dbg(2, 32'd0, "rst_dbg");

    // Reset again at clear counter 10.
    step();
    reset = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      if (n > 0) step();
      push(K_READY, 0, 32'd0, "init2_ready");
      if (n == 10) reset = 1'b0;
    end
    step();
    push(K_READY, 0, 32'd0, "init2_rst");
    step();
    reset = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      if (n > 0) step();
      push(K_READY, 0, {31'b0, (n == 32)}, "init3_ready");
    end
    chk_rd(0, 3, 32'd0, 1'b0, "post_busy3");
    chk_rd(1, 2, 32'd0, 1'b0, "post_reg2");
    chk_dbg(9, 32'd0, "post_dbg9");

    step(); step();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_regfile_sb.md
MIPS_CPU_REGFILE_SB -- requirements
Module: mips_cpu_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning index width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port read_index  input  NREAD*ADDR_WIDTH  packed read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 SHALL have port read_data  output  NREAD*DATA_WIDTH  packed read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port read_busy  output  NREAD  per-port flag: the indexed register has a pending write.
REQ-009 SHALL have port write_enable  input  1  commit write_data to write_reg.
REQ-010 SHALL have port write_reg  input  ADDR_WIDTH  write destination.
REQ-011 SHALL have port write_data  input  DATA_WIDTH  write value.
REQ-012 SHALL have port reserve_enable  input  1  mark reserve_reg as pending (load issued).
REQ-013 SHALL have port reserve_reg  input  ADDR_WIDTH  register to mark pending.
REQ-014 SHALL have port debug_index  input  ADDR_WIDTH  selects the register for debug_data.
REQ-015 SHALL have port debug_data  output  DATA_WIDTH  combinational value of register[debug_index]; index 2 gives v0.
REQ-016 SHALL have port ready  output  1  high once the initial clear sequence has finished.

Function
REQ-017 SHALL implement an FSM with states INIT and RUN; reset low forces INIT with clear counter = 0.
REQ-018 In INIT the block SHALL write zero to register[counter] each cycle, increment the counter, and enter RUN on the cycle after it writes index DEPTH-1 (ready rises DEPTH cycles after reset is released).
REQ-019 In INIT the block SHALL ignore write_enable and reserve_enable, return zero on every read_data and debug_data, and hold read_busy low.
REQ-020 In RUN, write_enable with write_reg != 0 SHALL update the register at the next edge; writes to index 0 SHALL be discarded.
REQ-021 Reads SHALL be combinational; index 0 SHALL always return zero and busy=0.
REQ-022 Busy bits SHALL be set by reserve_enable and cleared by write_enable to the same index; index 0 SHALL never become busy.
REQ-023 When reserve and write target the same index in one cycle, the data SHALL be written and busy SHALL end set (reservation wins).
REQ-024 Reserving an already busy register SHALL leave it busy; writing a non-busy register SHALL be legal and leave busy clear.
REQ-025 read_busy[k] SHALL reflect busy state before the current edge, except as modified by REQ-027.

Reset
REQ-026 A reset assertion at any time, including mid-INIT or mid-operation, SHALL abort the current activity, clear all busy bits, drop ready at the next edge, and restart the clear sequence from index 0.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN: when defined, a read whose index equals write_reg while write_enable is high in RUN (index != 0) SHALL return write_data and read_busy=0 in the same cycle; when undefined, that read SHALL return the old register value and the old busy bit.

Structure
REQ-028 A shared package mips_cpu_regfile_pkg SHALL hold the FSM state enum and the default width constants.
REQ-029 The busy-bit scoreboard SHALL be a sub-module mips_cpu_regfile_scoreboard (DEPTH bits, set/clear ports).

Verification
REQ-030 Release reset at cycle 0 -> ready low for 32 cycles, high at cycle 32; every debug_index reads 0.
REQ-031 Write 0xDEADBEEF to reg 2, then read index 2 on ports 0 and 1 -> both 0xDEADBEEF, debug_index=2 -> 0xDEADBEEF; write 0x1234 to reg 0 -> reg 0 reads 0.
REQ-032 Reserve reg 8 -> read_busy=1 for index 8; next cycle write 0x55 to reg 8 -> busy clears after the edge and reads return 0x55.
REQ-033 Same cycle: reserve reg 9 and write 0x77 to reg 9 -> afterwards reg 9 = 0x77 and busy=1.
REQ-034 Write 0xA5A5A5A5 to reg 4 while reading index 4 -> 0xA5A5A5A5 that cycle with REGFILE_BYPASS_EN, old value without it.
REQ-035 Assert reset at clear counter 10 with reg 3 busy -> ready low, busy clear, clear sequence restarts; ready high 32 cycles after release.
